// File: rtl/seg_display_ctrl.sv
// Multi-digit 7-segment display controller: latches a value, converts it to
// hex or (signed) decimal digits via sequential double-dabble, and drives segs.
module seg_display_ctrl #(
  parameter int DIGITS     = 4,
  parameter int WIDTH      = 32,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clock,
  input  logic                  reseta,
  input  logic                  escrever,
  input  logic [WIDTH-1:0]      entrada,
  input  logic [1:0]            modo,
  output logic                  ocupado,
  output logic                  estouro,
  output logic [7*DIGITS-1:0]   segs
);

  localparam int NBCD = (WIDTH * 3) / 10 + 1;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]       LAST     = CW'(WIDTH - 1);
  localparam logic [6:0]          SEG_DASH = 7'h40;
  localparam logic [7*DIGITS-1:0] SEGS_OFF = {(7*DIGITS){ACTIVE_LOW != 0}};

  typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;
  typedef enum logic [1:0] {
    MODE_HEX   = 2'b00,
    MODE_UDEC  = 2'b01,
    MODE_SDEC  = 2'b10,
    MODE_BLANK = 2'b11
  } mode_t;

  state_t              state_q, state_d;
  mode_t               mode_q;
  logic [WIDTH-1:0]    val_q;
  logic [WIDTH-1:0]    shift_q;
  logic [WIDTH-1:0]    mag_in;
  logic [4*NBCD-1:0]   bcd_q, bcd_next, adj;
  logic [CW-1:0]       cnt_q;
  logic                neg_q;

  logic [7*DIGITS-1:0]        lit_d;
  logic                       ovf_d;
  logic                       seen;
  logic [3:0]                 digit;
  int                         mag_digits;
  logic [4*(NBCD+DIGITS)-1:0] bcd_pad;
  logic [WIDTH+4*DIGITS-1:0]  val_pad;

  // Active-high segment pattern (a..g on bits 0..6) for one nibble.
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: seg_of = 7'h3F;  4'h1: seg_of = 7'h06;
      4'h2: seg_of = 7'h5B;  4'h3: seg_of = 7'h4F;
      4'h4: seg_of = 7'h66;  4'h5: seg_of = 7'h6D;
      4'h6: seg_of = 7'h7D;  4'h7: seg_of = 7'h07;
      4'h8: seg_of = 7'h7F;  4'h9: seg_of = 7'h6F;
      4'hA: seg_of = 7'h77;  4'hB: seg_of = 7'h7C;
      4'hC: seg_of = 7'h39;  4'hD: seg_of = 7'h5E;
      4'hE: seg_of = 7'h79;  default: seg_of = 7'h71;
    endcase
  endfunction

  assign ocupado = (state_q != IDLE);

  // Two's complement on WIDTH bits so the most negative value yields its true magnitude.
  assign mag_in = (modo == MODE_SDEC && entrada[WIDTH-1]) ? (~entrada) + WIDTH'(1) : entrada;

  always_ff @(posedge clock or posedge reseta) begin
    if (reseta) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (escrever) state_d = (modo == MODE_UDEC || modo == MODE_SDEC) ? CONVERT : LOAD;
      CONVERT: if (cnt_q == LAST) state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Double-dabble step: add 3 to every BCD digit >= 5, then shift in the next binary bit.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NBCD; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    bcd_next = {adj[4*NBCD-2:0], shift_q[WIDTH-1]};
  end

  always_comb begin
    lit_d      = '0;
    ovf_d      = 1'b0;
    seen       = 1'b0;
    digit      = '0;
    mag_digits = DIGITS;
    bcd_pad    = {{(4*DIGITS){1'b0}}, bcd_q};
    val_pad    = {{(4*DIGITS){1'b0}}, val_q};
    case (mode_q)
      MODE_HEX: begin
        for (int i = 0; i < DIGITS; i++) lit_d[7*i +: 7] = seg_of(val_pad[4*i +: 4]);
        for (int b = 0; b < WIDTH; b++) begin
          if (b >= 4*DIGITS && val_q[b]) ovf_d = 1'b1;
        end
      end
      MODE_UDEC, MODE_SDEC: begin
        if (neg_q) begin
          mag_digits = DIGITS - 1;
          lit_d[7*(DIGITS-1) +: 7] = SEG_DASH;
        end
        // Scan from the most significant digit so leading zeros stay blank.
        for (int i = DIGITS - 1; i >= 0; i--) begin
          if (i < mag_digits) begin
            digit = bcd_pad[4*i +: 4];
            if (digit != 4'd0 || i == 0) seen = 1'b1;
            if (seen) lit_d[7*i +: 7] = seg_of(digit);
          end
        end
        for (int i = 0; i < NBCD; i++) begin
          if (i >= mag_digits && bcd_q[4*i +: 4] != 4'd0) ovf_d = 1'b1;
        end
      end
      default: begin
        lit_d = '0;
        ovf_d = 1'b0;
      end
    endcase
    if (ovf_d) lit_d = {DIGITS{SEG_DASH}};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge reseta) begin
    if (reseta) begin
      // NOTE: every register, including the BCD and latched datapath, is cleared on reset.
      val_q   <= '0;
      mode_q  <= MODE_HEX;
      neg_q   <= 1'b0;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      segs    <= SEGS_OFF;
      estouro <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (escrever) begin
            val_q   <= entrada;
            mode_q  <= mode_t'(modo);
            neg_q   <= (modo == MODE_SDEC) && entrada[WIDTH-1];
            shift_q <= mag_in;
            bcd_q   <= '0;
            cnt_q   <= '0;
          end
        end
        CONVERT: begin
          bcd_q   <= bcd_next;
          shift_q <= shift_q << 1;
          cnt_q   <= cnt_q + 1'b1;
        end
        LOAD: begin
          segs    <= (ACTIVE_LOW != 0) ? ~lit_d : lit_d;
          estouro <= ovf_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seg_display_ctrl.md
SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of 7-segment digits driven.
REQ-002 SHALL have parameter WIDTH, default 32: width of the value to display.
REQ-003 SHALL have parameter ACTIVE_LOW, default 1: 1 means a lit segment is driven 0.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reseta, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port escrever, input, 1 bit: write strobe, sampled on the rising edge.
REQ-007 SHALL have port entrada, input, WIDTH bits: value to display.
REQ-008 SHALL have port modo, input, 2 bits: 00 hex, 01 unsigned decimal, 10 signed decimal, 11 blank.
REQ-009 SHALL have port ocupado, output, 1 bit: conversion in progress.
REQ-010 SHALL have port estouro, output, 1 bit: the last latched value does not fit in DIGITS.
REQ-011 SHALL have port segs, output, 7*DIGITS bits: digit i occupies [7i+6:7i], with segments a..g on bits 0..6; digit 0 is rightmost.

Function
REQ-012 SHALL implement states IDLE, CONVERT and LOAD; ocupado SHALL be 1 exactly when the state is not IDLE.
REQ-013 In IDLE, escrever=1 SHALL latch entrada and modo; modo 01/10 SHALL go to CONVERT, and modo 00/11 SHALL go to LOAD.
REQ-014 In CONVERT, the block SHALL do sequential double-dabble (add-3 then shift), one bit per cycle, for exactly WIDTH cycles, then go to LOAD.
REQ-015 The internal BCD register SHALL hold (WIDTH*3)/10+1 decimal digits.
REQ-016 In LOAD, the block SHALL register new segs and estouro in one cycle, then return to IDLE.
REQ-017 Latency, hex/blank: segs update on the 1st edge after the sampling edge, with ocupado high for 1 cycle.
REQ-018 Latency, decimal: segs update on the (WIDTH+1)th edge after the sampling edge, with ocupado high for WIDTH+1 cycles.
REQ-019 segs SHALL hold the previous display unchanged until LOAD completes; there SHALL be no partial updates.
REQ-020 escrever while ocupado=1 SHALL be ignored, with no queuing and no effect on the conversion in progress.
REQ-021 Hex mode: digit i SHALL show nibble i as 0-9, A, b, C, d, E, F, with no leading-zero blanking.
REQ-022 Hex mode: estouro SHALL be 1 if any bit at or above 4*DIGITS is nonzero.
REQ-023 Unsigned decimal: leading zeros SHALL be blanked, except that digit 0 always shows.
REQ-024 Unsigned decimal: estouro SHALL be 1 if any BCD digit at index DIGITS or above is nonzero.
REQ-025 Signed decimal: if the latched MSB is 1, the magnitude SHALL be the two's complement of the latched value, computed on WIDTH bits as unsigned, so the most negative value is handled.
REQ-026 Signed decimal, negative value: digit DIGITS-1 SHALL show '-' (segment g only); the magnitude SHALL occupy the remaining digits with leading blanking; estouro SHALL be 1 if any BCD digit at index DIGITS-1 or above is nonzero.
REQ-027 Signed decimal, non-negative value: the block SHALL behave identically to unsigned decimal.
REQ-028 When estouro=1, every digit SHALL show '-'.
REQ-029 Blank mode SHALL turn all segments off and set estouro=0.
REQ-030 Segment polarity SHALL be applied only at the output register, according to ACTIVE_LOW.

Reset
REQ-031 reseta=1 SHALL immediately force state IDLE, ocupado=0, estouro=0, all segments off (all ones when ACTIVE_LOW=1), and clear the latched and BCD registers.
REQ-032 Reset during CONVERT or LOAD SHALL abort the operation; no partial result SHALL ever appear on segs.
REQ-033 After reseta falls, the first rising edge with escrever=1 SHALL be accepted normally.

Verification (DIGITS=4, WIDTH=32, ACTIVE_LOW=1)
REQ-034 Assert reseta -> segs=28'hFFFFFFF, ocupado=0 and estouro=0 without waiting for a clock edge.
REQ-035 Hex mode, entrada=32'h0000BEEF -> after 1 edge the display reads "bEEF", estouro=0, ocupado high for 1 cycle.
REQ-036 Hex mode, entrada=32'h0000000 -> digit 0 = 7'b1000000 and all digits read '0'.
REQ-037 Unsigned decimal, entrada=1234 -> ocupado high for 33 cycles; the display reads "1234" on the 33rd edge; the old display holds until then.
REQ-038 Signed decimal, entrada=32'hFFFFFFFB -> display reads "-  5" with estouro=0.
REQ-039 Signed decimal, entrada=-1000 -> estouro=1 and the display reads "----".
REQ-040 Unsigned decimal, entrada=12345 -> estouro=1 and the display reads "----".
REQ-041 Strobe escrever with value 9 at cycle 5 of a conversion of 42 -> the display shows "42" and the 9 is dropped.
REQ-042 Assert reseta at cycle 10 of a conversion -> display blank; a following write completes normally.
